// File: rtl/i2s_pkg.sv
// Shared I2S framing types and helpers for the single-channel transmitter and receiver.
package i2s_pkg;

   typedef enum logic [1:0] {StIdle, StArmed, StShift, StPad} i2s_state_e;

   function automatic int unsigned cnt_width(input int unsigned bits);
      return $clog2(bits + 1);
   endfunction

endpackage

// File: rtl/i2soutsinglechannel_if.sv
// Sample handshake between the mixer core (master) and the I2S transmitter (slave).
interface i2soutsinglechannel_if #(
   parameter int unsigned BITS_PRECISION = 10
) ();

   logic [BITS_PRECISION-1:0] data_out;
   logic                      data_valid;
   logic                      data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave (input data_out, input data_valid, output data_ready);

endinterface

// File: rtl/i2s_hold_buffer.sv
// One-entry valid/ready sample buffer; a load frees the slot and may be refilled on the same edge.
module i2s_hold_buffer #(
   parameter int unsigned Width = 10
) (
   input  logic             sck,
   input  logic             rst,
   input  logic [Width-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             load,
   output logic [Width-1:0] hold_data,
   output logic             hold_valid
);

   logic [Width-1:0] data_q;
   logic             valid_q;
   logic             take;

   assign in_ready   = ~rst & (~valid_q | load);
   assign take       = in_valid & in_ready;
   assign hold_data  = data_q;
   assign hold_valid = valid_q;

   always_ff @(posedge sck) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (take) begin
            data_q <= in_data;
         end
         if (take) begin
            valid_q <= 1'b1;
         end else if (load) begin
            valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/i2soutsinglechannel.sv
// Single-channel I2S transmitter: buffers one sample and shifts it out MSB-first while enable is high.
module i2soutsinglechannel
   import i2s_pkg::*;
#(
   parameter int unsigned BITS_PRECISION = 10
) (
   input  logic                  sck,
   input  logic                  rst,
   input  logic                  enable,
   i2soutsinglechannel_if.slave  bus,
   output logic                  sd,
   output logic                  frame_done,
   output logic                  underrun
);

   localparam int unsigned CntW = cnt_width(BITS_PRECISION);
   localparam logic [CntW-1:0] LastCnt = CntW'(BITS_PRECISION - 1);

   i2s_state_e                state_q, state_d;
   logic [BITS_PRECISION-1:0] shreg_q, shreg_d;
   logic [CntW-1:0]           bit_cnt_q, bit_cnt_d;
   logic                      last_enable_q;
   logic                      frame_done_q, frame_done_d;
   logic                      underrun_q, underrun_d;
   logic                      load;
   logic [BITS_PRECISION-1:0] hold_data;
   logic                      hold_valid;

   i2s_hold_buffer #(
      .Width(BITS_PRECISION)
   ) u_hold (
      .sck       (sck),
      .rst       (rst),
      .in_data   (bus.data_out),
      .in_valid  (bus.data_valid),
      .in_ready  (bus.data_ready),
      .load      (load),
      .hold_data (hold_data),
      .hold_valid(hold_valid)
   );

   always_ff @(posedge sck) begin
      if (rst) begin
         state_q       <= StIdle;
         shreg_q       <= '0;
         bit_cnt_q     <= '0;
         last_enable_q <= 1'b0;
         frame_done_q  <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         shreg_q       <= shreg_d;
         bit_cnt_q     <= bit_cnt_d;
         last_enable_q <= enable;
         frame_done_q  <= frame_done_d;
         underrun_q    <= underrun_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bit_cnt_d    = bit_cnt_q;
      load         = 1'b0;
      underrun_d   = 1'b0;
      frame_done_d = last_enable_q & ~enable;
      unique case (state_q)
         StIdle: begin
            if (enable) begin
               // Frame started with nothing armed: send zeros for the whole slot.
               state_d    = StShift;
               shreg_d    = '0;
               bit_cnt_d  = CntW'(1);
               underrun_d = 1'b1;
            end else if (hold_valid) begin
               load    = 1'b1;
               shreg_d = hold_data;
               state_d = StArmed;
            end
         end
         StArmed: begin
            if (enable) begin
               shreg_d   = {shreg_q[BITS_PRECISION-2:0], 1'b0};
               bit_cnt_d = CntW'(1);
               state_d   = StShift;
            end
         end
         StShift: begin
            if (enable) begin
               shreg_d   = {shreg_q[BITS_PRECISION-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + CntW'(1);
               if (bit_cnt_q == LastCnt) begin
                  state_d = StPad;
               end
            end else begin
               state_d   = StIdle;
               shreg_d   = '0;
               bit_cnt_d = '0;
            end
         end
         StPad: begin
            if (!enable) begin
               state_d   = StIdle;
               shreg_d   = '0;
               bit_cnt_d = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign sd         = shreg_q[BITS_PRECISION-1];
   assign frame_done = frame_done_q;
   assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2soutsinglechannel.sv
// Bench for the single-channel I2S transmitter: directed frames plus random traffic vs a frame-level model.
module tb_i2soutsinglechannel;

   localparam int unsigned B = 10;

   logic sck = 1'b0;
   logic rst;
   logic enable;
   logic sd;
   logic frame_done;
   logic underrun;

   i2soutsinglechannel_if #(.BITS_PRECISION(B)) bus ();

   i2soutsinglechannel #(
      .BITS_PRECISION(B)
   ) dut (
      .sck       (sck),
      .rst       (rst),
      .enable    (enable),
      .bus       (bus),
      .sd        (sd),
      .frame_done(frame_done),
      .underrun  (underrun)
   );

   always #5 sck = ~sck;

   int total = 0;
   int bad   = 0;

   // Frame-level reference: accepted-but-unloaded samples, the armed word, and the frame in flight.
   logic [B-1:0] hq[$];
   logic         m_armed = 1'b0;
   logic [B-1:0] m_arm = '0;
   logic         m_in_frame = 1'b0;
   int           m_pos = 0;
   logic [B-1:0] m_word = '0;
   logic         m_prev_en = 1'b0;
   logic [B-1:0] rx_word = '0;
   int           rx_n = 0;
   logic [B-1:0] last_rx = '0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkw(input string tag, input logic [B-1:0] obs, input logic [B-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic vld, input logic [B-1:0] val);
      logic exp_load, exp_ready, exp_sd, exp_fd, exp_un;
      enable         = en;
      bus.data_valid = vld;
      bus.data_out   = val;
      #1;
      exp_load  = !en && !m_in_frame && !m_armed && (hq.size() != 0);
      exp_ready = (hq.size() == 0) || exp_load;
      if (m_in_frame) exp_sd = (m_pos < B) ? m_word[B-1-m_pos] : 1'b0;
      else if (m_armed) exp_sd = m_arm[B-1];
      else exp_sd = 1'b0;
      chk1("data_ready", bus.data_ready, exp_ready);
      chk1("sd", sd, exp_sd);
      exp_fd = m_prev_en && !en;
      exp_un = 1'b0;
      if (en) begin
         if (!m_in_frame) begin
            m_in_frame = 1'b1;
            m_pos      = 0;
            rx_n       = 0;
            rx_word    = '0;
            if (m_armed) begin
               m_word  = m_arm;
               m_armed = 1'b0;
            end else begin
               m_word = '0;
               exp_un = 1'b1;
            end
         end
         if (rx_n < B) begin
            rx_word = {rx_word[B-2:0], sd};
            rx_n++;
         end
         if (m_pos < B) m_pos++;
      end else if (m_in_frame) begin
         m_in_frame = 1'b0;
         if (rx_n == B) begin
            chkw("rx_word", rx_word, m_word);
            last_rx = rx_word;
         end
      end else if (exp_load) begin
         m_armed = 1'b1;
         m_arm   = hq.pop_front();
      end
      if (vld && exp_ready) hq.push_back(val);
      m_prev_en = en;
      @(posedge sck);
      #1;
      chk1("frame_done", frame_done, exp_fd);
      chk1("underrun", underrun, exp_un);
   endtask

   task automatic do_reset(input logic en);
      rst            = 1'b1;
      enable         = en;
      bus.data_valid = 1'b1;
      bus.data_out   = '1;
      #1;
      chk1("ready_in_rst", bus.data_ready, 1'b0);
      @(posedge sck);
      #1;
      chk1("sd_rst", sd, 1'b0);
      chk1("frame_done_rst", frame_done, 1'b0);
      chk1("underrun_rst", underrun, 1'b0);
      rst            = 1'b0;
      bus.data_valid = 1'b0;
      hq.delete();
      m_armed    = 1'b0;
      m_in_frame = 1'b0;
      m_prev_en  = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      bus.data_valid = 1'b0;
      bus.data_out   = '0;

      // 1: sample 55, three low edges, ten high edges, loopback word
      do_reset(1'b0);
      step(1'b0, 1'b1, B'(55));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      chkw("loopback_55", last_rx, B'(55));

      // 2: no sample -> zeros and a single underrun pulse
      step(1'b0, 1'b0, '0);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // 3: 0x3FF with a 12-edge window -> two pad zeros
      step(1'b0, 1'b1, B'(10'h3FF));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      repeat (12) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // 4: truncated 0x2AA after 4 bits, queued 0x0F0 goes out next frame
      step(1'b0, 1'b1, B'(10'h2AA));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, B'(10'h0F0));
      repeat (4) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // 5: back-to-back offers, stall until the load edge refills the slot
      step(1'b0, 1'b1, B'(10'h1C3));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, B'(10'h2E1));
      step(1'b0, 1'b1, B'(10'h07E));
      repeat (10) step(1'b1, 1'b1, B'(10'h07E));
      step(1'b0, 1'b1, B'(10'h07E));
      step(1'b0, 1'b1, B'(10'h07E));
      step(1'b0, 1'b1, B'(10'h333));
      step(1'b0, 1'b0, '0);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // 6: reset mid-shift of 0x155 drops the buffered sample
      step(1'b0, 1'b1, B'(10'h155));
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, B'(10'h0AA));
      repeat (4) step(1'b1, 1'b0, '0);
      do_reset(1'b1);
      do_reset(1'b1);
      repeat (10) step(1'b1, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      // Random gaps, frame lengths and offers
      for (int f = 0; f < 25; f++) begin
         int gap;
         int len;
         gap = $urandom_range(4, 1);
         len = $urandom_range(14, 1);
         for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom), B'($urandom));
         for (int h = 0; h < len; h++) step(1'b1, 1'($urandom), B'($urandom));
      end
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
